multicycle_control_unit: RTL and testbench

//  Moore FSM controller that drives the control inputs of the 32-bit multicycle MIPS DataPath.
//  It decodes Op/Funct from the datapath instruction register and sequences Fetch, Decode,

---
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/multicycle_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// Master is the controller; slave is the datapath side.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
) ();
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             PCWrite;
  logic             PCSrc;
  logic             RegWrite;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic             illegal_o;
  logic             retire_o;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, Funct, Zero,
    output PCWrite, PCSrc, RegWrite, IorD,
    output MemWrite, IRWrite, RegDst, MemtoReg,
    output ALUSrcA, ALUSrcB, ALUControl,
    output illegal_o, retire_o, instr_count
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWrite, PCSrc, RegWrite, IorD,
    input  MemWrite, IRWrite, RegDst, MemtoReg,
    input  ALUSrcA, ALUSrcB, ALUControl,
    input  illegal_o, retire_o, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle MIPS datapath.
// Counts retired instructions; flags unsupported opcodes.
module multicycle_control_unit #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_unit_if.master bus
);

  localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB = STATE_W'(10);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [CNT_W-1:0]   count;

  logic is_lw, is_sw, is_rt, is_beq, is_addi;
  logic r_ok, is_nop, is_legal;

  logic       pc_write, pc_src, reg_write, iord;
  logic       mem_write, ir_write, reg_dst, mem_to_reg;
  logic       src_a, illegal, retire;
  logic [1:0] src_b;
  logic [2:0] alu_ctl;
  logic [2:0] funct_ctl;

  // Opcode/funct classification used by DECODE and EXEC.
  always_comb begin
    is_lw    = bus.Op == 6'b100011;
    is_sw    = bus.Op == 6'b101011;
    is_rt    = bus.Op == 6'b000000;
    is_beq   = bus.Op == 6'b000100;
    is_addi  = bus.Op == 6'b001000;
    r_ok     = 1'b0;
    funct_ctl = 3'b010;
    unique case (bus.Funct)
      6'b100000: begin r_ok = 1'b1; funct_ctl = 3'b010; end
      6'b100010: begin r_ok = 1'b1; funct_ctl = 3'b110; end
      6'b100100: begin r_ok = 1'b1; funct_ctl = 3'b000; end
      6'b100101: begin r_ok = 1'b1; funct_ctl = 3'b001; end
      6'b101010: begin r_ok = 1'b1; funct_ctl = 3'b111; end
      default:   begin r_ok = 1'b0; funct_ctl = 3'b010; end
    endcase
    is_nop   = is_rt && bus.Funct == 6'b000000;
    is_legal = is_lw || is_sw || is_beq || is_addi
            || (is_rt && r_ok) || is_nop;
  end

  // Next-state selection.
  always_comb begin
    next_state = FETCH;
    unique case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_lw || is_sw: next_state = MEMADR;
          is_rt && r_ok:  next_state = EXEC;
          is_beq:         next_state = BRANCH;
          is_addi:        next_state = ADDIEX;
          default:        next_state = FETCH;
        endcase
      end
      MEMADR: next_state = is_lw ? MEMRD : MEMWR;
      MEMRD:  next_state = MEMWB;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // Moore output decode; enables are masked while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    src_a      = 1'b0;
    src_b      = 2'b00;
    alu_ctl    = 3'b010;
    illegal    = 1'b0;
    retire     = 1'b0;
    unique case (state)
      FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        src_b    = 2'b01;
      end
      DECODE: begin
        src_b   = 2'b10;
        retire  = is_nop;
        illegal = !is_legal;
      end
      MEMADR: begin
        src_a = 1'b1;
        src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      EXEC: begin
        src_a   = 1'b1;
        alu_ctl = funct_ctl;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        src_a    = 1'b1;
        alu_ctl  = 3'b110;
        pc_src   = 1'b1;
        pc_write = bus.Zero;
        retire   = 1'b1;
      end
      ADDIEX: begin
        src_a = 1'b1;
        src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: alu_ctl = 3'b000;
    endcase
    if (!reset) begin
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      count <= '0;
    end else begin
      state <= next_state;
      if (retire) count <= count + CNT_W'(1);
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCSrc       = pc_src;
  assign bus.RegWrite    = reg_write;
  assign bus.IorD        = iord;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.ALUControl  = alu_ctl;
  assign bus.illegal_o   = illegal;
  assign bus.retire_o    = retire;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit.
// Per-instruction cycle model; a second DUT uses a 3-bit counter to see wrap.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcwrite;
    logic       pcsrc;
    logic       regwrite;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       illegal;
    logic       retire;
  } ctl_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3;
  localparam int C_ADDI = 4, C_NOP = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   chk = 0;
  ctl_t exp_ctl;
  logic [31:0] exp_cnt;
  logic [31:0] cnt;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(32)) bus ();
  multicycle_control_unit_if #(.CNT_W(3))  bus3 ();

  assign bus3.Op    = bus.Op;
  assign bus3.Funct = bus.Funct;
  assign bus3.Zero  = bus.Zero;

  multicycle_control_unit #(.STATE_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  multicycle_control_unit #(.STATE_W(4), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic int ncyc(input int cls);
    case (cls)
      C_LW:              return 5;
      C_SW, C_R, C_ADDI: return 4;
      C_BEQ:             return 3;
      default:           return 2;
    endcase
  endfunction

  // Expected controls for step k of an instruction of class cls.
  function automatic ctl_t model(input int cls, input logic [5:0] f,
                                 input logic z, input int k);
    ctl_t c;
    c = '0;
    c.alu = 3'b010;
    if (k == 0) begin
      c.irwrite = 1; c.pcwrite = 1; c.srcb = 2'b01;
    end else if (k == 1) begin
      c.srcb = 2'b10;
      c.retire = (cls == C_NOP);
      c.illegal = (cls == C_ILL);
    end else if (k == 2) begin
      c.srca = 1;
      case (cls)
        C_R:     begin c.srcb = 2'b00; c.alu = alu_of(f); end
        C_BEQ:   begin
          c.srcb = 2'b00; c.alu = 3'b110; c.pcsrc = 1;
          c.pcwrite = z; c.retire = 1;
        end
        default: c.srcb = 2'b10;
      endcase
    end else if (k == ncyc(cls) - 1) begin
      c.retire = 1;
      c.regwrite = (cls != C_SW);
      c.memtoreg = (cls == C_LW);
      c.regdst = (cls == C_R);
      c.iord = (cls == C_SW);
      c.memwrite = (cls == C_SW);
    end else begin
      c.iord = 1;
    end
    return c;
  endfunction

  function automatic ctl_t actual();
    ctl_t c;
    c.pcwrite  = bus.PCWrite;
    c.pcsrc    = bus.PCSrc;
    c.regwrite = bus.RegWrite;
    c.iord     = bus.IorD;
    c.memwrite = bus.MemWrite;
    c.irwrite  = bus.IRWrite;
    c.regdst   = bus.RegDst;
    c.memtoreg = bus.MemtoReg;
    c.srca     = bus.ALUSrcA;
    c.srcb     = bus.ALUSrcB;
    c.alu      = bus.ALUControl;
    c.illegal  = bus.illegal_o;
    c.retire   = bus.retire_o;
    return c;
  endfunction

  task automatic pin(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Compare process: full check in normal mode, enables/count in reset.
  always @(negedge clk) begin
    if (chk == 1) begin
      tests++;
      if (actual() !== exp_ctl
          || bus.instr_count !== exp_cnt
          || bus3.instr_count !== exp_cnt[2:0]) begin
        fails++;
        $display("FAIL ctl t=%0t: got %h cnt %h/%h want %h cnt %h/%h",
                 $time, actual(), bus.instr_count, bus3.instr_count,
                 exp_ctl, exp_cnt, exp_cnt[2:0]);
      end
    end else if (chk == 2) begin
      tests++;
      if ({bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite,
           bus.illegal_o, bus.retire_o} !== 6'b0
          || bus.instr_count !== 32'd0 || bus3.instr_count !== 3'd0) begin
        fails++;
        $display("FAIL reset t=%0t: en %b cnt %h want en 000000 cnt 0",
                 $time, {bus.PCWrite, bus.RegWrite, bus.MemWrite,
                 bus.IRWrite, bus.illegal_o, bus.retire_o},
                 bus.instr_count);
      end
    end
  end

  // Drive one instruction starting in FETCH; abort>=0 resets at that step.
  task automatic run(input int cls, input logic [5:0] op,
                     input logic [5:0] f, input int zm, input int abort);
    bus.Op = op;
    bus.Funct = f;
    chk = 1;
    for (int k = 0; k < ncyc(cls); k++) begin
      bus.Zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
      exp_ctl = model(cls, f, bus.Zero, k);
      exp_cnt = cnt;
      if (k == abort) begin
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk = 2;
        cnt = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        return;
      end
      @(posedge clk);
      if (exp_ctl.retire) cnt++;
      #1;
    end
  endtask

  function automatic logic [5:0] rand_funct();
    logic [5:0] t [5];
    t[0] = 6'b100000; t[1] = 6'b100010; t[2] = 6'b100100;
    t[3] = 6'b100101; t[4] = 6'b101010;
    return t[$urandom_range(0, 4)];
  endfunction

  function automatic logic legal_op(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011
        || o == 6'b000100 || o == 6'b001000;
  endfunction

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int cls;
    logic [5:0] op, f;
    pin("lw_cycles", ncyc(C_LW), 5);
    pin("beq_cycles", ncyc(C_BEQ), 3);
    pin("sub_alu", int'(model(C_R, 6'b100010, 1'b0, 2).alu), 6);
    pin("slt_alu", int'(model(C_R, 6'b101010, 1'b0, 2).alu), 7);
    pin("lw_wb", int'({model(C_LW, 6'd0, 1'b0, 4).regwrite,
                       model(C_LW, 6'd0, 1'b0, 4).memtoreg}), 3);
    pin("ill_pulse", int'(model(C_ILL, 6'd0, 1'b0, 1).illegal), 1);

    reset = 1'b0;
    bus.Op = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero = 1'b0;
    cnt = 0;
    @(posedge clk);
    #1;
    chk = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    run(C_LW,   6'b100011, 6'd7,      2, -1);
    run(C_SW,   6'b101011, 6'd3,      2, -1);
    run(C_R,    6'b000000, 6'b100010, 2, -1);
    run(C_R,    6'b000000, 6'b101010, 2, -1);
    run(C_BEQ,  6'b000100, 6'd0,      1, -1);
    run(C_BEQ,  6'b000100, 6'd0,      0, -1);
    run(C_ADDI, 6'b001000, 6'd9,      2, -1);
    run(C_ILL,  6'b111111, 6'd0,      2, -1);
    run(C_NOP,  6'b000000, 6'd0,      2, -1);
    run(C_ILL,  6'b000000, 6'b000001, 2, -1);
    run(C_LW,   6'b100011, 6'd0,      2, 3);

    for (int i = 0; i < 300; i++) begin
      cls = $urandom_range(0, 6);
      f = 6'($urandom);
      case (cls)
        C_LW:   op = 6'b100011;
        C_SW:   op = 6'b101011;
        C_BEQ:  op = 6'b000100;
        C_ADDI: op = 6'b001000;
        C_R:    begin op = 6'b000000; f = rand_funct(); end
        C_NOP:  begin op = 6'b000000; f = 6'd0; end
        default: begin
          op = 6'($urandom);
          while (legal_op(op)) op = 6'($urandom);
        end
      endcase
      run(cls, op, f, 2, (i % 97 == 50) ? 2 : -1);
    end

    chk = 0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
